// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - control word, result/immediate encodings and ALU decode shared by the decode stage
package decode_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
    logic [1:0] WordWidth;
    logic       LoadSignExt;
    logic       JalSrc;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - IF/ID-side, writeback and ID/EX-side signals of the decode stage
interface decode_stage_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 32
);
  import decode_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [PC_WIDTH-1:0]   PCD;
  logic [PC_WIDTH-1:0]   PCPlus4D;
  logic                  RegWriteW;
  logic [ADDR_WIDTH-1:0] RdW;
  logic [DATA_WIDTH-1:0] ResultW;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  ctrl_t                 CtrlE;
  logic [DATA_WIDTH-1:0] Rd1E;
  logic [DATA_WIDTH-1:0] Rd2E;
  logic [ADDR_WIDTH-1:0] Rs1E;
  logic [ADDR_WIDTH-1:0] Rs2E;
  logic [ADDR_WIDTH-1:0] RdE;
  logic [DATA_WIDTH-1:0] ImmExtE;
  logic [PC_WIDTH-1:0]   PCE;
  logic [PC_WIDTH-1:0]   PCPlus4E;
  logic                  hazard_stall;

  modport master (
    output in_valid, InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, flush, out_ready,
    input  in_ready, out_valid, CtrlE, Rd1E, Rd2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E,
    input  hazard_stall
  );

  modport slave (
    input  in_valid, InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, flush, out_ready,
    output in_ready, out_valid, CtrlE, Rd1E, Rd2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E,
    output hazard_stall
  );

endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - opcode/funct decode into the ctrl_t control word and immediate format
module control_unit
  import decode_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output ctrl_t      ctrl,
  output imm_src_e   imm_src
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    imm_src = IMM_I;
    case (op)
      OP_LOAD: begin
        ctrl.RegWrite    = 1'b1;
        ctrl.ResultSrc   = RES_MEM;
        ctrl.ALUSrc      = 1'b1;
        ctrl.WordWidth   = funct3[1:0];
        ctrl.LoadSignExt = ~funct3[2];
      end
      OP_STORE: begin
        ctrl.MemWrite  = 1'b1;
        ctrl.ALUSrc    = 1'b1;
        ctrl.WordWidth = funct3[1:0];
        imm_src        = IMM_S;
      end
      OP_REG: begin
        ctrl.RegWrite   = 1'b1;
        ctrl.ALUControl = alu_decode(funct3, funct7b5);
      end
      OP_IMM: begin
        ctrl.RegWrite   = 1'b1;
        ctrl.ALUSrc     = 1'b1;
        ctrl.ALUControl = alu_decode(funct3, 1'b0);
      end
      OP_BRANCH: begin
        ctrl.Branch     = 1'b1;
        ctrl.ALUControl = ALU_SUB;
        imm_src         = IMM_B;
      end
      OP_JAL: begin
        ctrl.RegWrite  = 1'b1;
        ctrl.ResultSrc = RES_PC4;
        ctrl.Jump      = 1'b1;
        imm_src        = IMM_J;
      end
      OP_JALR: begin
        ctrl.RegWrite  = 1'b1;
        ctrl.ResultSrc = RES_PC4;
        ctrl.Jump      = 1'b1;
        ctrl.ALUSrc    = 1'b1;
        ctrl.JalSrc    = 1'b1;
      end
      OP_LUI: begin
        ctrl.RegWrite   = 1'b1;
        ctrl.ResultSrc  = RES_ALU;
        ctrl.ALUSrc     = 1'b1;
        ctrl.ALUControl = ALU_PASSB;
        imm_src         = IMM_U;
      end
      default: begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
      end
    endcase
  end

endmodule

// File: rtl/decode_regfile_bypass.sv
// rtl/decode_regfile_bypass.sv - two-read one-write register file, x0 hardwired, write-through on read
module decode_regfile_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  assign wr_en = we & (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Writeback data is forwarded so a same-cycle write is seen by decode.
  assign rdata1 = (raddr1 == '0) ? '0 :
                  (wr_en && (waddr == raddr1)) ? wdata : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (wr_en && (waddr == raddr2)) ? wdata : regs_q[raddr2];

endmodule

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - builds the 32-bit immediate for the I/S/B/J/U instruction formats
module sign_extend
  import decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_src_e    imm_src,
  output logic [31:0] imm_ext
);

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm_ext = {instr[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode, register read and ID/EX register with handshake, flush and load-use bubble
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  decode_stage_pipe_if.slave bus
);

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  ctrl_t                 ctrl_dec;
  imm_src_e              imm_src;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  advance;
  logic                  hazard;
  logic                  hold;
  logic                  take;

  logic                  out_valid_q, out_valid_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc4_q, pc4_d;

  assign rs1 = ADDR_WIDTH'(bus.InstrD[19:15]);
  assign rs2 = ADDR_WIDTH'(bus.InstrD[24:20]);
  assign rd  = ADDR_WIDTH'(bus.InstrD[11:7]);

  control_unit u_control (
    .op       (bus.InstrD[6:0]),
    .funct3   (bus.InstrD[14:12]),
    .funct7b5 (bus.InstrD[30]),
    .ctrl     (ctrl_dec),
    .imm_src  (imm_src)
  );

  sign_extend u_sign_extend (
    .instr   (bus.InstrD[31:7]),
    .imm_src (imm_src),
    .imm_ext (imm32)
  );

  assign imm_ext = DATA_WIDTH'($signed(imm32));

  decode_regfile_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.RegWriteW),
    .waddr  (bus.RdW),
    .wdata  (bus.ResultW),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // A load sitting in ID/EX cannot forward in time to a dependent instruction.
  assign advance = bus.out_ready | ~out_valid_q;
  assign hazard  = out_valid_q & (ctrl_q.ResultSrc == RES_MEM) & (rd_q != '0) &
                   ((rd_q == rs1) | (rd_q == rs2)) & bus.in_valid;

  assign bus.hazard_stall = hazard & ~bus.flush;
  assign bus.in_ready     = advance & (~hazard | bus.flush);

  assign hold = ~bus.flush & ~advance;
  assign take = ~bus.flush & advance & ~hazard & bus.in_valid;

  // Everything that is neither a hold nor a take loads a bubble.
  always_comb begin
    out_valid_d = 1'b0;
    ctrl_d      = CTRL_BUBBLE;
    rd1_d       = '0;
    rd2_d       = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_d        = '0;
    imm_d       = '0;
    pc_d        = '0;
    pc4_d       = '0;
    if (hold) begin
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      pc4_d       = pc4_q;
    end else if (take) begin
      out_valid_d = 1'b1;
      ctrl_d      = ctrl_dec;
      rd1_d       = rd1;
      rd2_d       = rd2;
      rs1_d       = rs1;
      rs2_d       = rs2;
      rd_d        = rd;
      imm_d       = imm_ext;
      pc_d        = bus.PCD;
      pc4_d       = bus.PCPlus4D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      pc4_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.CtrlE     = ctrl_q;
  assign bus.Rd1E      = rd1_q;
  assign bus.Rd2E      = rd2_q;
  assign bus.Rs1E      = rs1_q;
  assign bus.Rs2E      = rs2_q;
  assign bus.RdE       = rd_q;
  assign bus.ImmExtE   = imm_q;
  assign bus.PCE       = pc_q;
  assign bus.PCPlus4E  = pc4_q;

endmodule
